cic_comp_fir: RTL and testbench
===============================

Name:
cic_comp_fir

Overview:
- Serial-MAC decimating compensation FIR, placed directly downstream of the CIC decimator in the DSM receive path.
- Consumes the CIC's 16-bit output stream and its qualifying strobe.
- Corrects CIC passband droop and decimates by DECI.
- Emits a 16-bit stream with its own one-cycle strobe.
- Coefficients are held in runtime-writable registers.

Parameters:
- TAPS, 16, number of FIR taps (legal 2..64).
- DECI, 2, decimation ratio (legal 1..16).
- CSHIFT, 14, right shift applied to the accumulator. Coefficients are Q2.14 at the default.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high, sampled on rising clk.
- cke  in  1  input sample strobe, one-cycle pulse (driven from the upstream cke_out).
- din  in  16  signed input sample, valid when cke=1.
- coef_we  in  1  coefficient write enable.
- coef_addr  in  $clog2(TAPS)  coefficient index k.
- coef_data  in  16  signed coefficient value.
- dout  out  16  signed filtered output sample.
- cke_out  out  1  one-cycle pulse, dout updated this cycle.
- busy  out  1  high while a MAC pass is in progress.
- overrun  out  1  sticky flag: a sample arrived while busy.

Behaviour:
- Reset values: dout=0, cke_out=0, busy=0, overrun=0, phase=0, write pointer=0, sample buffer all 0.
  - Coefficients after reset: coef[0]=16384, all others 0, giving a decimating passthrough at CSHIFT=14.
- Sample buffer is a TAPS-deep circular buffer.
  - An accepted sample is written at the write pointer; the pointer then increments modulo TAPS.
- Accepting a sample:
  - A sample is accepted when cke=1 and state=IDLE.
  - On acceptance: if phase==DECI-1, set phase to 0 and enter MAC; otherwise phase increments.
  - DECI=1: every accepted sample starts a pass.
- State machine: IDLE -> MAC -> OUT -> IDLE.
  - IDLE -> MAC on an accepted sample that completes a decimation phase.
  - MAC lasts exactly TAPS cycles with one multiply-accumulate per cycle.
  - Cycle k of MAC adds coef[k]*x[n-k], where x[n] is the sample just accepted.
  - The accumulator is cleared on MAC entry.
  - OUT lasts 1 cycle: dout is registered and cke_out is pulsed.
- busy=1 throughout MAC and OUT.
- Latency: dout and cke_out update on the (TAPS+2)th rising edge after the edge that sampled the decimating cke.
  - cke_out is high for exactly one cycle.
- Arithmetic:
  - Product is 32-bit signed; the accumulator is 32+$clog2(TAPS) bits signed.
  - Result = (acc + 2^(CSHIFT-1)) >>> CSHIFT, i.e. round half toward +inf.
  - Result saturates to [-32768, 32767]; there is no wrap.
- Overrun:
  - cke=1 while busy=1 drops the sample: no buffer write, no pointer change, no phase change.
  - The drop sets overrun=1, which stays set until rst.
  - The MAC pass in progress is unaffected.
- Coefficient writes:
  - When coef_we=1, coef[coef_addr] takes coef_data on that edge and is used from the next cycle.
  - Writes are allowed in any state; a write during MAC may affect the current result, and the bench writes only in IDLE.
  - coef_addr >= TAPS is ignored.
- Simultaneous cke and coef_we: both act independently.
- rst mid-MAC: the pass is aborted.
  - All state returns to reset values next cycle, including the coefficient defaults.
  - No cke_out is emitted.

Test Plan:
1. Post-reset passthrough, DECI=2: feed din 1, 2, 3, 4, cke spaced 20 cycles -> dout 2 then 4. cke_out comes 18 edges after the cke of samples 2 and 4. No other cke_out.
2. Boxcar gain: write coef[0..15]=16384, feed 20 samples of din=100 -> output 1600 once the buffer is full. Earlier outputs ramp as 200, 400, ... (DECI=2).
3. Saturation: boxcar coefficients with constant din=32767 -> dout=32767. Constant din=-32768 -> dout=-32768. overrun stays 0.
4. Rounding: coef[0]=8192, others 0, DECI=1 -> din=3 gives dout=2; din=-3 gives dout=-1.
5. Overrun: DECI=1, cke 5 cycles after the decimating cke (while busy) -> overrun=1, pending result equals the value without the dropped sample, write pointer unchanged.
6. Reset mid-MAC: assert rst 8 cycles into a pass -> no cke_out, dout=0, coef[0]=16384. The next pass after reset yields the post-reset passthrough value.

Source files
------------

// File: rtl/cic_comp_fir_if.sv
// Port bundle for the CIC compensation FIR: sample strobe/data in, coefficient
// write port, filtered strobe/data out plus status and FSM debug state.
interface cic_comp_fir_if #(
    parameter int TAPS = 16
);
    localparam int AW = $clog2(TAPS);

    // Strobe semantics: cke/din and cke_out/dout are valid-only (no ready).
    // busy is advisory; a cke seen while busy is dropped and flags overrun.
    logic                 cke;
    logic signed [15:0]   din;
    logic                 coef_we;
    logic [AW-1:0]        coef_addr;
    logic signed [15:0]   coef_data;
    logic signed [15:0]   dout;
    logic                 cke_out;
    logic                 busy;
    logic                 overrun;
    logic [1:0]           state_dbg;

    modport master (
        output cke, din, coef_we, coef_addr, coef_data,
        input  dout, cke_out, busy, overrun, state_dbg
    );

    modport slave (
        input  cke, din, coef_we, coef_addr, coef_data,
        output dout, cke_out, busy, overrun, state_dbg
    );
endinterface

// File: rtl/cic_comp_fir.sv
// Serial-MAC decimating FIR that flattens CIC passband droop; one tap per
// cycle through a registered multiplier, runtime-writable Q2.14 coefficients.
module cic_comp_fir #(
    parameter int TAPS   = 16,
    parameter int DECI   = 2,
    parameter int CSHIFT = 14
) (
    input  logic            clk,
    input  logic            rst,
    cic_comp_fir_if.slave   bus
);
    localparam int AW  = $clog2(TAPS);
    localparam int PW  = (DECI > 1) ? $clog2(DECI) : 1;
    localparam int ACW = 32 + AW;
    localparam logic [AW:0]            TAPS_W  = (AW+1)'(TAPS);
    localparam logic signed [ACW-1:0]  RND     = ACW'(1) <<< (CSHIFT - 1);
    localparam logic signed [ACW-1:0]  SAT_MAX = ACW'(32767);
    localparam logic signed [ACW-1:0]  SAT_MIN = ACW'(-32768);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          phase_q, phase_d;
    logic [AW-1:0]          wptr_q, wptr_d;
    logic [AW-1:0]          base_q, base_d;
    logic [AW-1:0]          tap_q, tap_d;
    logic signed [31:0]     prod_q, prod_d;
    logic                   prod_vld_q, prod_vld_d;
    logic signed [ACW-1:0]  acc_q, acc_d;
    logic                   res_pend_q, res_pend_d;
    logic signed [15:0]     dout_q, dout_d;
    logic                   cke_out_q, cke_out_d;
    logic                   overrun_q, overrun_d;
    logic signed [15:0]     smp_q [TAPS];
    logic signed [15:0]     smp_d [TAPS];
    logic signed [15:0]     coef_q [TAPS];
    logic signed [15:0]     coef_d [TAPS];

    logic [AW:0]            rd_sum;
    logic [AW-1:0]          rd_idx;
    logic signed [ACW-1:0]  rnd_sum;
    logic signed [ACW-1:0]  shifted;

    // Tap k reads x[n-k]: walk backwards from the slot the newest sample landed in.
    always_comb begin
        rd_sum = {1'b0, base_q} + TAPS_W - {1'b0, tap_q};
        if (rd_sum >= TAPS_W) begin
            rd_sum = rd_sum - TAPS_W;
        end
        rd_idx = rd_sum[AW-1:0];
    end

    always_comb begin
        rnd_sum = acc_q + RND;
        shifted = rnd_sum >>> CSHIFT;
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        wptr_d     = wptr_q;
        base_d     = base_q;
        tap_d      = tap_q;
        prod_d     = prod_q;
        prod_vld_d = 1'b0;
        acc_d      = acc_q;
        res_pend_d = 1'b0;
        dout_d     = dout_q;
        cke_out_d  = 1'b0;
        overrun_d  = overrun_q;
        smp_d      = smp_q;
        coef_d     = coef_q;

        if (bus.coef_we && (int'(bus.coef_addr) < TAPS)) begin
            coef_d[bus.coef_addr] = bus.coef_data;
        end

        if (bus.cke) begin
            if (state_q == IDLE) begin
                smp_d[wptr_q] = bus.din;
                wptr_d = (wptr_q == AW'(TAPS - 1)) ? '0 : wptr_q + 1'b1;
                if (phase_q == PW'(DECI - 1)) begin
                    phase_d = '0;
                    state_d = MAC;
                    base_d  = wptr_q;
                    tap_d   = '0;
                    acc_d   = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end else begin
                overrun_d = 1'b1;
            end
        end

        // Products are registered; the accumulator trails the multiplier by one cycle.
        case (state_q)
            MAC: begin
                prod_d     = 32'(coef_q[tap_q]) * 32'(smp_q[rd_idx]);
                prod_vld_d = 1'b1;
                if (prod_vld_q) begin
                    acc_d = acc_q + ACW'(prod_q);
                end
                if (tap_q == AW'(TAPS - 1)) begin
                    state_d = OUT;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            OUT: begin
                acc_d      = acc_q + ACW'(prod_q);
                res_pend_d = 1'b1;
                state_d    = IDLE;
            end
            default: begin
            end
        endcase

        // acc_q still holds the finished sum here even if a new pass starts this cycle.
        if (res_pend_q) begin
            cke_out_d = 1'b1;
            if (shifted > SAT_MAX) begin
                dout_d = 16'sh7fff;
            end else if (shifted < SAT_MIN) begin
                dout_d = 16'sh8000;
            end else begin
                dout_d = shifted[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            wptr_q     <= '0;
            base_q     <= '0;
            tap_q      <= '0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
            res_pend_q <= 1'b0;
            dout_q     <= '0;
            cke_out_q  <= 1'b0;
            overrun_q  <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                smp_q[i]  <= '0;
                coef_q[i] <= (i == 0) ? 16'sd16384 : 16'sd0;
            end
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            wptr_q     <= wptr_d;
            base_q     <= base_d;
            tap_q      <= tap_d;
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            acc_q      <= acc_d;
            res_pend_q <= res_pend_d;
            dout_q     <= dout_d;
            cke_out_q  <= cke_out_d;
            overrun_q  <= overrun_d;
            smp_q      <= smp_d;
            coef_q     <= coef_d;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.cke_out   = cke_out_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.overrun   = overrun_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir: a DECI=2 and a DECI=1 instance share clk/rst.
module tb_cic_comp_fir;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    cic_comp_fir_if #(.TAPS(16)) a_if();
    cic_comp_fir_if #(.TAPS(16)) b_if();

    cic_comp_fir #(.TAPS(16), .DECI(2), .CSHIFT(14)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    cic_comp_fir #(.TAPS(16), .DECI(1), .CSHIFT(14)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wcoef(input bit sel, input int addr, input int data);
        @(negedge clk);
        if (sel) begin
            b_if.coef_we = 1'b1; b_if.coef_addr = 4'(addr); b_if.coef_data = 16'(data);
        end else begin
            a_if.coef_we = 1'b1; a_if.coef_addr = 4'(addr); a_if.coef_data = 16'(data);
        end
        @(negedge clk);
        a_if.coef_we = 1'b0;
        b_if.coef_we = 1'b0;
    endtask

    // Drive one sample, then watch 30 edges for the output pulse.
    task automatic feed(input bit sel, input int d, input bit exp_out, input int exp_val,
                        input string tag);
        int lat;
        int pulses;
        lat = 0;
        pulses = 0;
        @(negedge clk);
        if (sel) begin
            b_if.din = 16'(d); b_if.cke = 1'b1;
        end else begin
            a_if.din = 16'(d); a_if.cke = 1'b1;
        end
        @(negedge clk);
        a_if.cke = 1'b0;
        b_if.cke = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (exp_out && n == 3) check({tag, ".busy"}, sel ? b_if.busy : a_if.busy, 1);
            if (sel ? b_if.cke_out : a_if.cke_out) begin
                pulses++;
                if (lat == 0) lat = n;
            end
        end
        check({tag, ".pulses"}, pulses, exp_out ? 1 : 0);
        if (exp_out) begin
            check({tag, ".lat"}, lat, 18);
            check({tag, ".dout"}, sel ? b_if.dout : a_if.dout, exp_val);
            check({tag, ".idle"}, sel ? b_if.busy : a_if.busy, 0);
        end
    endtask

    initial begin
        int pulses;
        total = 0;
        bad = 0;
        rst = 1'b1;
        a_if.cke = 0; a_if.din = 0; a_if.coef_we = 0; a_if.coef_addr = 0; a_if.coef_data = 0;
        b_if.cke = 0; b_if.din = 0; b_if.coef_we = 0; b_if.coef_addr = 0; b_if.coef_data = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst.dout", a_if.dout, 0);
        check("rst.cke_out", a_if.cke_out, 0);
        check("rst.busy", a_if.busy, 0);
        check("rst.overrun", a_if.overrun, 0);
        check("rst.state", a_if.state_dbg, 0);

        // Post-reset passthrough, decimate by 2
        feed(0, 1, 0, 0, "t1.s1");
        feed(0, 2, 1, 2, "t1.s2");
        feed(0, 3, 0, 0, "t1.s3");
        feed(0, 4, 1, 4, "t1.s4");

        // Boxcar gain ramps then settles at 16*100
        do_reset();
        for (int k = 0; k < 16; k++) wcoef(0, k, 16384);
        for (int i = 1; i <= 20; i++) begin
            feed(0, 100, (i % 2) == 0, ((i > 16) ? 16 : i) * 100, "t2.box");
        end

        // Saturation both rails
        do_reset();
        for (int k = 0; k < 16; k++) wcoef(0, k, 16384);
        for (int i = 1; i <= 16; i++) feed(0, 32767, (i % 2) == 0, 32767, "t3.pos");
        do_reset();
        for (int k = 0; k < 16; k++) wcoef(0, k, 16384);
        for (int i = 1; i <= 16; i++) feed(0, -32768, (i % 2) == 0, -32768, "t3.neg");
        check("t3.overrun", a_if.overrun, 0);

        // Round half toward +inf, DECI=1
        do_reset();
        wcoef(1, 0, 8192);
        feed(1, 3, 1, 2, "t4.pos");
        feed(1, -3, 1, -1, "t4.neg");

        // Overrun: a sample arriving mid-pass is dropped without touching the buffer
        do_reset();
        feed(1, 10, 1, 10, "t5.pre");
        check("t5.ovr0", b_if.overrun, 0);
        @(negedge clk);
        b_if.din = 16'sd20; b_if.cke = 1'b1;
        @(negedge clk);
        b_if.cke = 1'b0;
        repeat (4) @(negedge clk);
        b_if.din = 16'sd99; b_if.cke = 1'b1;
        @(negedge clk);
        b_if.cke = 1'b0;
        pulses = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            if (b_if.cke_out) pulses++;
        end
        check("t5.pulses", pulses, 1);
        check("t5.dout", b_if.dout, 20);
        check("t5.ovr1", b_if.overrun, 1);
        wcoef(1, 1, 16384);
        feed(1, 30, 1, 50, "t5.ptr");
        check("t5.sticky", b_if.overrun, 1);

        // Reset mid-pass restores coefficient defaults and suppresses the output
        do_reset();
        wcoef(0, 0, 8192);
        feed(0, 5, 0, 0, "t6.s1");
        @(negedge clk);
        a_if.din = 16'sd6; a_if.cke = 1'b1;
        @(negedge clk);
        a_if.cke = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            if (a_if.cke_out) pulses++;
        end
        check("t6.pulses", pulses, 0);
        check("t6.dout", a_if.dout, 0);
        check("t6.busy", a_if.busy, 0);
        check("t6.state", a_if.state_dbg, 0);
        feed(0, 7, 0, 0, "t6.s3");
        feed(0, 8, 1, 8, "t6.s4");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
